// File: rtl/kyber_decompress_stream.sv
// kyber_decompress_stream: two-stage elastic Kyber decompressor, round(3329*x/2^d); `DECOMP_CENTER_EN selects signed centered output
module kyber_decompress_stream #(
  parameter int N_COEF = 256,
  parameter int CNT_W  = 8,
  parameter int COEF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        d_i,
  input  logic              valid_i,
  input  logic [10:0]       data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [COEF_W-1:0] data_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic              err_o
);
  logic             s1_v_q, s1_last_q, s1_bad_q;
  logic [23:0]      s1_p_q;
  logic [3:0]       s1_d_q, d_q, dc;
  logic [CNT_W-1:0] cnt_q;
  logic             s2_free, in_fire, first, bad, cnt_last;
  logic [10:0]      xm;
  logic [23:0]      p, sum;
  logic [11:0]      r;
  logic [COEF_W-1:0] rc;
  assign s2_free  = !valid_o || ready_i;
  assign ready_o  = !s1_v_q || s2_free;
  assign in_fire  = valid_i && ready_o;
  assign first    = cnt_q == '0;
  assign cnt_last = cnt_q == CNT_W'(N_COEF - 1);
  // S1 datapath: the polynomial's d comes from d_i on its first coefficient, then from the latch
  always_comb begin
    dc  = first ? d_i : d_q;
    bad = dc == 4'd0 || dc > 4'd11;
    xm  = data_i & ~(11'h7ff << dc);
    p   = (24'(xm) << 11) + (24'(xm) << 10) + (24'(xm) << 8) + 24'(xm);
  end
  // S2 datapath: round-half-up division by 2^d, optionally folded into the signed range
  always_comb begin
    sum = s1_p_q + (24'd1 << (s1_d_q - 4'd1));
    r   = 12'(sum >> s1_d_q);
`ifdef DECOMP_CENTER_EN
    rc  = s1_bad_q ? '0 : r > 12'd1664 ? COEF_W'(r) - COEF_W'(3329) : COEF_W'(r);
`else
    rc  = s1_bad_q ? '0 : COEF_W'(r);
`endif
  end
  // Input side: framing counter, d latch, sticky error and the S1 register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      d_q       <= '0;
      err_o     <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_p_q    <= '0;
      s1_d_q    <= '0;
      s1_last_q <= 1'b0;
      s1_bad_q  <= 1'b0;
    end else if (in_fire) begin
      cnt_q     <= cnt_last ? '0 : cnt_q + 1'b1;
      d_q       <= dc;
      err_o     <= err_o || (first && bad);
      s1_v_q    <= 1'b1;
      s1_p_q    <= p;
      s1_d_q    <= dc;
      s1_last_q <= cnt_last;
      s1_bad_q  <= bad;
    end else if (s2_free) begin
      s1_v_q    <= 1'b0;
    end
  end
  // Output register: refills whenever it is empty or being drained
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
    end else if (s2_free) begin
      valid_o <= s1_v_q;
      if (s1_v_q) begin
        data_o <= rc;
        last_o <= s1_last_q;
      end
    end
  end
endmodule

// File: tb/tb_kyber_decompress_stream.sv
// tb_kyber_decompress_stream: directed vectors with a reference queue for streaming, stall, error and reset cases
module tb_kyber_decompress_stream;
  logic        clk_i = 0, rst_i = 0, valid_i = 0, ready_i = 1;
  logic [3:0]  d_i = 0;
  logic [10:0] data_i = 0;
  logic        ready_o, valid_o, last_o, err_o;
  logic [15:0] data_o;
  int vec = 0, mis = 0, mcnt = 0, md = 0, lastcnt = 0;
  bit fin;
  logic [16:0] q[$];

  kyber_decompress_stream dut (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(d_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .last_o(last_o),
    .ready_i(ready_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input int d, input int x, input bit lst);
    int r;
    int xm;
    xm = x & ((1 << d) - 1);
    r = (d == 0 || d > 11) ? 0 : (3329 * xm + (1 << (d - 1))) >> d;
`ifdef DECOMP_CENTER_EN
    if (r > 1664) r = r - 3329;
`endif
    return {lst, 16'(r)};
  endfunction

  task automatic tick();
    logic [16:0] e;
    #2;
    fin = 0;
    if (rst_i) begin
      q.delete();
      mcnt = 0;
    end else begin
      fin = valid_i && ready_o;
      if (valid_o && ready_i) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("stream_data", data_o, e[15:0]);
          chk("stream_last", last_o, e[16]);
          if (last_o) lastcnt++;
        end
      end
      if (fin) begin
        if (mcnt == 0) md = d_i;
        q.push_back(model(md, data_i, mcnt == 255));
        mcnt = (mcnt + 1) % 256;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1; valid_i = 0;
    tick();
    rst_i = 0;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 1);
    chk("rst_data_o", data_o, 0);
    chk("rst_last_o", last_o, 0);
    chk("rst_err_o", err_o, 0);
  endtask

  task automatic single(input int d, input int x, input logic [15:0] exp);
    do_reset();
    ready_i = 1; d_i = 4'(d); data_i = 11'(x); valid_i = 1;
    tick();
    valid_i = 0;
    chk("lat_not_early", valid_o, 0);
    tick();
    chk("lat_valid", valid_o, 1);
    chk("vec_data", data_o, exp);
    tick();
  endtask

  task automatic drain();
    valid_i = 0; ready_i = 1;
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    chk("drained", q.size(), 0);
  endtask

  initial begin
    int c, idx, l0;
    do_reset();
`ifdef DECOMP_CENTER_EN
    single(1, 1, 16'hF980);
    single(4, 15, 16'hFF30);
    single(10, 512, 16'hF980);
    single(11, 2047, 16'hFFFE);
`else
    single(1, 1, 16'd1665);
    single(4, 15, 16'd3121);
    single(10, 512, 16'd1665);
    single(11, 2047, 16'd3327);
`endif
    single(5, 0, 16'd0);
    single(4, 16'h7ff, model(4, 15, 0)[15:0]);

    // full polynomial with a mid-stream d change, then a new polynomial with a new d
    do_reset();
    lastcnt = 0; ready_i = 1; valid_i = 1;
    for (int i = 0; i < 256; i++) begin
      d_i = (i < 100) ? 4'd10 : 4'd3;
      data_i = 11'(i % 1024);
      tick();
    end
    d_i = 4; data_i = 15; tick();
    d_i = 9; data_i = 11'h7ff; tick();
    drain();
    chk("last_count", lastcnt, 1);

    // backpressure mid-stream
    do_reset();
    d_i = 10; idx = 0; c = 0;
    while (idx < 40 && c < 200) begin
      valid_i = 1;
      data_i = 11'((idx * 37) % 1024);
      ready_i = !(c >= 10 && c < 15);
      #1;
      if (c >= 12 && c < 15) begin
        chk("stall_ready_o", ready_o, 0);
        chk("stall_valid_o", valid_o, 1);
        chk("stall_hold", data_o, q[0][15:0]);
      end
      tick();
      if (fin) idx++;
      c++;
    end
    chk("stall_accepted", idx, 40);
    drain();

    // unsupported d: sticky error, zero data, normal framing
    do_reset();
    lastcnt = 0; d_i = 12; ready_i = 1; valid_i = 1;
    for (int i = 0; i < 256; i++) begin
      data_i = 11'(i);
      tick();
      if (i == 0) chk("err_set", err_o, 1);
    end
    drain();
    chk("err_sticky", err_o, 1);
    chk("err_last_count", lastcnt, 1);
    do_reset();

    // reset with a full stalled pipeline
    d_i = 10; data_i = 100; valid_i = 1; ready_i = 0;
    l0 = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (fin) l0++;
    end
    #1;
    chk("full_accepts", l0, 2);
    chk("full_ready_o", ready_o, 0);
    do_reset();
`ifdef DECOMP_CENTER_EN
    single(1, 1, 16'hF980);
`else
    single(1, 1, 16'd1665);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
